// File: rtl/normaliza_seq.sv
// Multi-cycle post-add normaliser: carry renormalisation, iterative left shift
// after cancellation, and zero/subnormal/overflow classification.
module normaliza_seq #(
    parameter int MANT_W = 10,
    parameter int EXP_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valido,
    output logic              in_pronto,
    input  logic [MANT_W+1:0] mantissa_resultado,
    input  logic [EXP_W-1:0]  expoente_resultado,
    output logic              out_valido,
    input  logic              out_pronto,
    output logic [MANT_W-1:0] mantissa_normalizada,
    output logic [EXP_W-1:0]  expoente_ajustado,
    output logic              flag_zero,
    output logic              flag_subnormal,
    output logic              flag_overflow
);

    typedef enum logic [1:0] {OCIOSO, AVALIA, DESLOCA, FIM} estado_t;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_UM  = EXP_W'(1);

    estado_t           r_estado, w_prox;
    logic [MANT_W+1:0] r_m, w_m;
    logic [EXP_W-1:0]  r_e, w_e;
    logic [MANT_W-1:0] r_frac, w_frac;
    logic [EXP_W-1:0]  r_exp, w_exp;
    logic              r_zero, w_zero;
    logic              r_sub, w_sub;
    logic              r_ovf, w_ovf;

    logic [MANT_W+1:0] w_m_sh;
    logic [EXP_W-1:0]  w_e_inc;
    logic [EXP_W-1:0]  w_e_dec;

    assign w_m_sh  = r_m << 1;
    assign w_e_inc = r_e + EXP_UM;
    assign w_e_dec = r_e - EXP_UM;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_m      <= '0;
            r_e      <= '0;
            r_frac   <= '0;
            r_exp    <= '0;
            r_zero   <= 1'b0;
            r_sub    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_m      <= w_m;
            r_e      <= w_e;
            r_frac   <= w_frac;
            r_exp    <= w_exp;
            r_zero   <= w_zero;
            r_sub    <= w_sub;
            r_ovf    <= w_ovf;
        end
    end

    always_comb begin
        w_prox = r_estado;
        w_m    = r_m;
        w_e    = r_e;
        w_frac = r_frac;
        w_exp  = r_exp;
        w_zero = r_zero;
        w_sub  = r_sub;
        w_ovf  = r_ovf;
        case (r_estado)
            OCIOSO: begin
                if (in_valido) begin
                    w_m    = mantissa_resultado;
                    w_e    = expoente_resultado;
                    w_zero = 1'b0;
                    w_sub  = 1'b0;
                    w_ovf  = 1'b0;
                    w_prox = AVALIA;
                end
            end
            AVALIA: begin
                w_prox = FIM;
                if (r_m == '0) begin
                    w_frac = '0;
                    w_exp  = '0;
                    w_zero = 1'b1;
                end else if (r_m[MANT_W+1]) begin
                    // e already all-ones counts as overflow too, not a wrap to 0
                    if (r_e >= EXP_MAX - EXP_UM) begin
                        w_frac = '0;
                        w_exp  = EXP_MAX;
                        w_ovf  = 1'b1;
                    end else begin
                        w_frac = r_m[MANT_W:1];
                        w_exp  = w_e_inc;
                    end
                end else if (r_m[MANT_W]) begin
                    w_frac = r_m[MANT_W-1:0];
                    w_exp  = r_e;
                end else if (r_e <= EXP_UM) begin
                    w_frac = r_m[MANT_W-1:0];
                    w_exp  = '0;
                    w_sub  = 1'b1;
                end else begin
                    w_prox = DESLOCA;
                end
            end
            DESLOCA: begin
                w_m = w_m_sh;
                w_e = w_e_dec;
                if (w_m_sh[MANT_W]) begin
                    w_frac = w_m_sh[MANT_W-1:0];
                    w_exp  = w_e_dec;
                    w_prox = FIM;
                end else if (w_e_dec == EXP_UM) begin
                    w_frac = w_m_sh[MANT_W-1:0];
                    w_exp  = '0;
                    w_sub  = 1'b1;
                    w_prox = FIM;
                end
            end
            FIM: begin
                if (out_pronto) w_prox = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    assign in_pronto            = (r_estado == OCIOSO);
    assign out_valido           = (r_estado == FIM);
    assign mantissa_normalizada = r_frac;
    assign expoente_ajustado    = r_exp;
    assign flag_zero            = r_zero;
    assign flag_subnormal       = r_sub;
    assign flag_overflow        = r_ovf;

endmodule
